// File: rtl/rover_display_sequencer_pkg.sv
// Shared types and constants for the rover display sequencer: state encoding,
// coordinate/trig widths and the 15-degree-sector Q1.8 cos/sin tables.
package rover_display_pkg;

    localparam int DIST_W   = 8;
    localparam int COORD_W  = 12;
    localparam int TRIG_W   = 10;
    localparam int SECTOR_W = 4;
    localparam int ORI_W    = 6;
    localparam int LOC_W    = SECTOR_W + DIST_W;
    localparam int PROD_W   = DIST_W + 1 + TRIG_W;
    localparam int CALC_W   = 14;

    localparam logic [SECTOR_W-1:0] SECTOR_MAX = 4'd12;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        MUL_X,
        MUL_Y,
        SCALE,
        WAIT_VS
    } seq_state_e;

    typedef logic signed [TRIG_W-1:0] trig_t;

    // Q1.8: 256 represents 1.0; sector k is 15*k degrees from +x
    localparam trig_t COS_LUT [0:12] = '{
        10'sd256,  10'sd247,  10'sd222,  10'sd181,  10'sd128,  10'sd66,  10'sd0,
        -10'sd66, -10'sd128, -10'sd181, -10'sd222, -10'sd247, -10'sd256
    };

    localparam trig_t SIN_LUT [0:12] = '{
        10'sd0,   10'sd66,  10'sd128, 10'sd181, 10'sd222, 10'sd247, 10'sd256,
        10'sd247, 10'sd222, 10'sd181, 10'sd128, 10'sd66,  10'sd0
    };

    function automatic logic [SECTOR_W-1:0] sat_sector(input logic [SECTOR_W-1:0] k);
        return (k > SECTOR_MAX) ? SECTOR_MAX : k;
    endfunction

    function automatic logic signed [COORD_W-1:0] clamp_coord(
        input logic signed [CALC_W-1:0] v,
        input logic signed [CALC_W-1:0] lo,
        input logic signed [CALC_W-1:0] hi
    );
        logic signed [CALC_W-1:0] r;
        r = v;
        if (v < lo) begin
            r = lo;
        end else if (v > hi) begin
            r = hi;
        end
        return COORD_W'(r);
    endfunction

endpackage

// File: rtl/rover_display_sequencer_if.sv
// Front-end / writer-side signal bundle for the rover display sequencer.
interface rover_display_sequencer_if
    import rover_display_pkg::*;
;
    logic                       vsync;
    logic [LOC_W-1:0]           location;
    logic                       new_data;
    logic [ORI_W-1:0]           orientation;
    logic                       orientation_ready;
    logic signed [COORD_W-1:0]  rover_x;
    logic signed [COORD_W-1:0]  rover_y;
    logic [ORI_W-1:0]           rover_orientation;
    logic                       shape_sel;
    logic                       busy;
    logic                       commit;

    modport slave (
        input  vsync, location, new_data, orientation, orientation_ready,
        output rover_x, rover_y, rover_orientation, shape_sel, busy, commit
    );

    modport master (
        output vsync, location, new_data, orientation, orientation_ready,
        input  rover_x, rover_y, rover_orientation, shape_sel, busy, commit
    );

endinterface

// File: rtl/rover_display_sequencer_trig.sv
// Combinational sector -> Q1.8 cos/sin lookup used by the shared multiplier.
module rover_trig_lut
    import rover_display_pkg::*;
(
    input  logic [SECTOR_W-1:0] sector_i,
    output trig_t               cos_o,
    output trig_t               sin_o
);

    always_comb begin
        cos_o = '0;
        sin_o = '0;
        if (sector_i <= SECTOR_MAX) begin
            cos_o = COS_LUT[sector_i];
            sin_o = SIN_LUT[sector_i];
        end
    end

endmodule

// File: rtl/rover_display_sequencer.sv
// Polar-to-screen converter that commits rover position/heading on vsync fall.
// Optional ROVER_SEQ_FILTER_EN: commits the midpoint of old and new position.
module rover_display_sequencer
    import rover_display_pkg::*;
#(
    parameter int SCALE_SHIFT = 1,
    parameter int X_MIN       = -512,
    parameter int X_MAX       = 511,
    parameter int Y_MIN       = 0,
    parameter int Y_MAX       = 767,
    parameter int OFFSCREEN_Y = -64
) (
    input  logic                        vclock,
    input  logic                        reset,
    rover_display_sequencer_if.slave    bus
);

    localparam logic signed [CALC_W-1:0] X_LO = CALC_W'(X_MIN);
    localparam logic signed [CALC_W-1:0] X_HI = CALC_W'(X_MAX);
    localparam logic signed [CALC_W-1:0] Y_LO = CALC_W'(Y_MIN);
    localparam logic signed [CALC_W-1:0] Y_HI = CALC_W'(Y_MAX);

    seq_state_e                 state_q;
    logic                       vsync_q;
    logic                       pending_loc_q;
    logic [LOC_W-1:0]           pend_loc_q;
    logic                       pending_ori_q;
    logic [ORI_W-1:0]           pend_ori_q;
    logic [SECTOR_W-1:0]        sector_q;
    logic [DIST_W-1:0]          dist_q;
    logic signed [CALC_W-1:0]   px_q;
    logic signed [CALC_W-1:0]   py_q;
    logic signed [COORD_W-1:0]  x_stage_q;
    logic signed [COORD_W-1:0]  y_stage_q;
    logic                       loc_conv_q;
    logic signed [COORD_W-1:0]  rover_x_q;
    logic signed [COORD_W-1:0]  rover_y_q;
    logic [ORI_W-1:0]           rover_ori_q;
    logic                       shape_q;
    logic                       commit_q;
`ifdef ROVER_SEQ_FILTER_EN
    logic                       first_fix_q;
    logic signed [COORD_W:0]    x_sum_d;
    logic signed [COORD_W:0]    y_sum_d;
`endif

    trig_t                      cos_w;
    trig_t                      sin_w;
    trig_t                      mul_b_d;
    logic signed [DIST_W:0]     mul_a_d;
    logic signed [PROD_W-1:0]   prod_d;
    logic signed [CALC_W-1:0]   mul_res_d;
    logic signed [COORD_W-1:0]  x_commit_d;
    logic signed [COORD_W-1:0]  y_commit_d;
    logic                       vsync_fall_d;

    rover_trig_lut u_trig_lut (
        .sector_i (sector_q),
        .cos_o    (cos_w),
        .sin_o    (sin_w)
    );

    // One multiplier serves both axes; the trig operand follows the state.
    always_comb begin
        mul_a_d   = {1'b0, dist_q};
        mul_b_d   = (state_q == MUL_Y) ? sin_w : cos_w;
        prod_d    = mul_a_d * mul_b_d;
        mul_res_d = CALC_W'(prod_d >>> 8);
    end

    always_comb begin
`ifdef ROVER_SEQ_FILTER_EN
        x_sum_d = (COORD_W+1)'(rover_x_q) + (COORD_W+1)'(x_stage_q);
        y_sum_d = (COORD_W+1)'(rover_y_q) + (COORD_W+1)'(y_stage_q);
        if (first_fix_q) begin
            x_commit_d = x_stage_q;
            y_commit_d = y_stage_q;
        end else begin
            x_commit_d = COORD_W'(x_sum_d >>> 1);
            y_commit_d = COORD_W'(y_sum_d >>> 1);
        end
`else
        x_commit_d = x_stage_q;
        y_commit_d = y_stage_q;
`endif
    end

    assign vsync_fall_d = vsync_q && !bus.vsync;

    always_ff @(posedge vclock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            vsync_q       <= 1'b1;
            pending_loc_q <= 1'b0;
            pend_loc_q    <= '0;
            pending_ori_q <= 1'b0;
            pend_ori_q    <= '0;
            sector_q      <= '0;
            dist_q        <= '0;
            px_q          <= '0;
            py_q          <= '0;
            x_stage_q     <= '0;
            y_stage_q     <= '0;
            loc_conv_q    <= 1'b0;
            rover_x_q     <= '0;
            rover_y_q     <= COORD_W'(OFFSCREEN_Y);
            rover_ori_q   <= '0;
            shape_q       <= 1'b0;
            commit_q      <= 1'b0;
`ifdef ROVER_SEQ_FILTER_EN
            first_fix_q   <= 1'b1;
`endif
        end else begin
            vsync_q  <= bus.vsync;
            commit_q <= 1'b0;

            // Strobes always land in the pending buffers; latest report wins.
            if (bus.new_data) begin
                pending_loc_q <= 1'b1;
                pend_loc_q    <= bus.location;
            end
            if (bus.orientation_ready) begin
                pending_ori_q <= 1'b1;
                pend_ori_q    <= bus.orientation;
            end

            case (state_q)
                IDLE: begin
                    if (pending_loc_q || bus.new_data) begin
                        state_q <= CAPTURE;
                    end else if (pending_ori_q || bus.orientation_ready) begin
                        state_q <= WAIT_VS;
                    end
                end
                CAPTURE: begin
                    sector_q <= sat_sector(pend_loc_q[LOC_W-1:DIST_W]);
                    dist_q   <= pend_loc_q[DIST_W-1:0];
                    if (!bus.new_data) begin
                        pending_loc_q <= 1'b0;
                    end
                    state_q <= MUL_X;
                end
                MUL_X: begin
                    px_q    <= mul_res_d;
                    state_q <= MUL_Y;
                end
                MUL_Y: begin
                    py_q    <= mul_res_d;
                    state_q <= SCALE;
                end
                SCALE: begin
                    x_stage_q  <= clamp_coord(px_q <<< SCALE_SHIFT, X_LO, X_HI);
                    y_stage_q  <= clamp_coord(py_q <<< SCALE_SHIFT, Y_LO, Y_HI);
                    loc_conv_q <= 1'b1;
                    state_q    <= WAIT_VS;
                end
                WAIT_VS: begin
                    if (vsync_fall_d) begin
                        commit_q <= 1'b1;
                        if (loc_conv_q) begin
                            rover_x_q  <= x_commit_d;
                            rover_y_q  <= y_commit_d;
                            loc_conv_q <= 1'b0;
`ifdef ROVER_SEQ_FILTER_EN
                            first_fix_q <= 1'b0;
`endif
                        end
                        if (pending_ori_q) begin
                            rover_ori_q <= pend_ori_q;
                            shape_q     <= 1'b1;
                            if (!bus.orientation_ready) begin
                                pending_ori_q <= 1'b0;
                            end
                        end
                        state_q <= pending_loc_q ? CAPTURE : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rover_x           = rover_x_q;
    assign bus.rover_y           = rover_y_q;
    assign bus.rover_orientation = rover_ori_q;
    assign bus.shape_sel         = shape_q;
    assign bus.commit            = commit_q;
    assign bus.busy              = (state_q != IDLE) || pending_loc_q || pending_ori_q;

endmodule

// File: tb/tb_rover_display_sequencer.sv
// Scoreboard bench: two instances (SCALE_SHIFT 1 and 2) share stimulus; a monitor
// pops hand-computed expectations on every commit pulse.
module tb_rover_display_sequencer;

    logic vclock;
    logic reset;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int x;
        int y;
        int ori;
        int shape;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

`ifdef ROVER_SEQ_FILTER_EN
    bit have_fix = 0;
    int prev_x1 = 0, prev_y1 = 0, prev_x2 = 0, prev_y2 = 0;
`endif

    rover_display_sequencer_if bus1 ();
    rover_display_sequencer_if bus2 ();

    assign bus2.vsync             = bus1.vsync;
    assign bus2.location          = bus1.location;
    assign bus2.new_data          = bus1.new_data;
    assign bus2.orientation       = bus1.orientation;
    assign bus2.orientation_ready = bus1.orientation_ready;

    rover_display_sequencer #(.SCALE_SHIFT(1)) dut (
        .vclock (vclock),
        .reset  (reset),
        .bus    (bus1)
    );

    rover_display_sequencer #(.SCALE_SHIFT(2)) dut2 (
        .vclock (vclock),
        .reset  (reset),
        .bus    (bus2)
    );

    initial vclock = 1'b0;
    always #5 vclock = ~vclock;

    task automatic chk(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, expv);
        end
    endtask

    // Raw hand values are the unfiltered conversion; the filter build averages them.
    task automatic push_exp(input int x1, input int y1, input int x2, input int y2,
                            input int ori, input int shape);
        exp_t e1;
        exp_t e2;
`ifdef ROVER_SEQ_FILTER_EN
        if (have_fix) begin
            x1 = (prev_x1 + x1) >>> 1;
            y1 = (prev_y1 + y1) >>> 1;
            x2 = (prev_x2 + x2) >>> 1;
            y2 = (prev_y2 + y2) >>> 1;
        end
        have_fix = 1;
        prev_x1 = x1; prev_y1 = y1; prev_x2 = x2; prev_y2 = y2;
`endif
        e1 = '{x: x1, y: y1, ori: ori, shape: shape};
        e2 = '{x: x2, y: y2, ori: ori, shape: shape};
        q1.push_back(e1);
        q2.push_back(e2);
    endtask

    task automatic compare_commit(input int id, input exp_t e, input int x, input int y,
                                  input int ori, input int shape);
        $display("commit dut%0d: x=%0d y=%0d ori=%0d shape=%0d (exp x=%0d y=%0d ori=%0d shape=%0d)",
                 id, x, y, ori, shape, e.x, e.y, e.ori, e.shape);
        chk($sformatf("dut%0d rover_x", id), x, e.x);
        chk($sformatf("dut%0d rover_y", id), y, e.y);
        chk($sformatf("dut%0d rover_orientation", id), ori, e.ori);
        chk($sformatf("dut%0d shape_sel", id), shape, e.shape);
    endtask

    // Monitor: every commit pulse consumes one expectation per instance.
    initial begin
        exp_t e;
        forever begin
            @(negedge vclock);
            if (!reset && bus1.commit) begin
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dut1 unexpected commit: got x=%0d y=%0d, expected no commit",
                             bus1.rover_x, bus1.rover_y);
                end else begin
                    e = q1.pop_front();
                    compare_commit(1, e, int'(bus1.rover_x), int'(bus1.rover_y),
                                   int'(bus1.rover_orientation), int'(bus1.shape_sel));
                end
            end
            if (!reset && bus2.commit) begin
                if (q2.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dut2 unexpected commit: got x=%0d y=%0d, expected no commit",
                             bus2.rover_x, bus2.rover_y);
                end else begin
                    e = q2.pop_front();
                    compare_commit(2, e, int'(bus2.rover_x), int'(bus2.rover_y),
                                   int'(bus2.rover_orientation), int'(bus2.shape_sel));
                end
            end
        end
    end

    task automatic strobe(input logic [11:0] loc, input bit ori_en, input logic [5:0] ori);
        @(posedge vclock); #1;
        bus1.location          = loc;
        bus1.new_data          = 1'b1;
        bus1.orientation       = ori;
        bus1.orientation_ready = ori_en;
        @(posedge vclock); #1;
        bus1.new_data          = 1'b0;
        bus1.orientation_ready = 1'b0;
    endtask

    task automatic vsync_fall();
        @(posedge vclock); #1;
        bus1.vsync = 1'b0;
        repeat (2) @(posedge vclock);
        #1;
        bus1.vsync = 1'b1;
    endtask

    task automatic run_vec(input logic [11:0] loc, input int x1, input int y1,
                           input int x2, input int y2, input int ori, input int shape);
        push_exp(x1, y1, x2, y2, ori, shape);
        strobe(loc, 1'b0, 6'd0);
        repeat (8) @(posedge vclock);
        vsync_fall();
        repeat (4) @(posedge vclock);
    endtask

    initial begin
        reset                  = 1'b1;
        bus1.vsync             = 1'b1;
        bus1.location          = '0;
        bus1.new_data          = 1'b0;
        bus1.orientation       = '0;
        bus1.orientation_ready = 1'b0;
        repeat (3) @(posedge vclock);
        #1 reset = 1'b0;

        // Reset state; monitor flags any stray commit while idling.
        repeat (3) @(negedge vclock);
        chk("reset rover_x", int'(bus1.rover_x), 0);
        chk("reset rover_y", int'(bus1.rover_y), -64);
        chk("reset rover_orientation", int'(bus1.rover_orientation), 0);
        chk("reset shape_sel", int'(bus1.shape_sel), 0);
        chk("reset busy", int'(bus1.busy), 0);
        vsync_fall();
        repeat (3) @(posedge vclock);

        // Sector 6 points straight up.
        run_vec({4'd6, 8'd100}, 0, 200, 0, 400, 0, 0);

        // Sector 4 with a vsync fall during conversion that must be ignored.
        push_exp(100, 172, 200, 344, 0, 0);
        strobe({4'd4, 8'd100}, 1'b0, 6'd0);
        bus1.vsync = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge vclock);
            chk("hold busy", int'(bus1.busy), 1);
            chk("hold rover_x", int'(bus1.rover_x), 0);
            chk("hold rover_y", int'(bus1.rover_y), 200);
            if (i == 1) begin
                @(posedge vclock); #1;
                bus1.vsync = 1'b1;
            end
        end
        vsync_fall();
        repeat (4) @(posedge vclock);

        // Clamp at shift 2, and sector 15 saturating to sector 12.
        run_vec({4'd0, 8'd255}, 510, 0, 511, 0, 0, 0);
        run_vec({4'd15, 8'd255}, -510, 0, -512, 0, 0, 0);

        // Two reports before one vsync: both commit, in order, one frame apart.
        push_exp(20, 0, 40, 0, 0, 0);
        push_exp(100, 0, 200, 0, 0, 0);
        strobe({4'd0, 8'd10}, 1'b0, 6'd0);
        repeat (2) @(posedge vclock);
        strobe({4'd0, 8'd50}, 1'b0, 6'd0);
        repeat (6) @(posedge vclock);
        vsync_fall();
        repeat (8) @(posedge vclock);
        vsync_fall();
        repeat (4) @(posedge vclock);

        // Simultaneous orientation and location strobes -> single commit.
        push_exp(0, 100, 0, 200, 9, 1);
        strobe({4'd6, 8'd50}, 1'b1, 6'd9);
        repeat (8) @(posedge vclock);
        vsync_fall();
        repeat (4) @(posedge vclock);

        // Follow-up location; midpoint in the filter build, raw otherwise.
        run_vec({4'd0, 8'd50}, 100, 0, 200, 0, 9, 1);

        // Reset mid-conversion discards the pending report.
        strobe({4'd4, 8'd100}, 1'b0, 6'd0);
        @(posedge vclock); #1;
        reset = 1'b1;
        @(negedge vclock);
        chk("midreset rover_x", int'(bus1.rover_x), 0);
        chk("midreset rover_y", int'(bus1.rover_y), -64);
        chk("midreset rover_orientation", int'(bus1.rover_orientation), 0);
        chk("midreset shape_sel", int'(bus1.shape_sel), 0);
        chk("midreset busy", int'(bus1.busy), 0);
        @(posedge vclock); #1;
        reset = 1'b0;
`ifdef ROVER_SEQ_FILTER_EN
        have_fix = 0;
`endif
        repeat (8) @(posedge vclock);
        vsync_fall();
        repeat (4) @(negedge vclock);
        chk("post-reset busy", int'(bus1.busy), 0);
        chk("post-reset rover_y", int'(bus2.rover_y), -64);

        chk("dut1 pending expectations", q1.size(), 0);
        chk("dut2 pending expectations", q2.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
